// File: rtl/prog_mem_pkg.sv
// Shared types and default sizes for the programmable memory block.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/mem_array.sv
// Single write port, single synchronous read port storage array.
module mem_array
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem.sv
// Memory with sequential programming pass and run-mode direct access.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              low_clr,
    input  logic              prog_mode,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              low_load,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              low_o_en,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W:0]   prog_count,
    output logic              prog_done
);

    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W:0]   r_prog_count;
    logic              r_prog_done;
    logic              r_wr_ready;

    logic              w_in_prog;
    logic              w_enter;
    logic              w_last;
    logic              w_prog_wr;
    logic              w_run_wr;
    logic              w_we;
    logic              w_re;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_in_prog = (r_state == PROG);
    assign w_enter   = (r_state == IDLE) && prog_mode;
    assign w_last    = (r_prog_count == LAST);
    assign w_prog_wr = w_in_prog && prog_mode && wr_valid;
    assign w_run_wr  = !w_in_prog && !low_load;
    assign w_we      = w_prog_wr || w_run_wr;
    assign w_waddr   = w_in_prog ? r_prog_count[ADDR_W-1:0] : addr;
    assign w_wdata   = w_in_prog ? wr_data : data_in;
    // Suppress the read on the entry edge so data_out is 0 for all of PROG.
    assign w_re      = !w_in_prog && !w_enter && !low_o_en;

    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            r_state      <= IDLE;
            r_prog_count <= '0;
            r_prog_done  <= 1'b0;
            r_wr_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (prog_mode) begin
                        r_state      <= PROG;
                        r_prog_count <= '0;
                        r_wr_ready   <= 1'b1;
                        r_prog_done  <= 1'b0;
                    end
                end
                PROG: begin
                    if (!prog_mode) begin
                        r_state    <= IDLE;
                        r_wr_ready <= 1'b0;
                    end else if (wr_valid) begin
                        r_prog_count <= r_prog_count + ONE;
                        if (w_last) begin
                            r_state     <= DONE;
                            r_wr_ready  <= 1'b0;
                            r_prog_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!prog_mode) begin
                        r_state     <= IDLE;
                        r_prog_done <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_wr_ready  <= 1'b0;
                    r_prog_done <= 1'b0;
                end
            endcase
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_rst_n (low_clr),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (addr),
        .o_rdata (data_out)
    );

    assign wr_ready   = r_wr_ready;
    assign prog_count = r_prog_count;
    assign prog_done  = r_prog_done;

endmodule
